fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the RV32IC pipeline.

---
 rtl/fwd_hazard_unit_if.sv | 35 +++
 rtl/fwd_hazard_unit.sv | 76 +++++++
 tb/tb_fwd_hazard_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request bundle into the forwarding/hazard unit and its stall/select results.
// Parameters must match the fwd_hazard_unit instance that the bundle is bound to.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    input  stall, fwd_sel_a, fwd_sel_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    output stall, fwd_sel_a, fwd_sel_b, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit tracking in-flight writers S1..S_DEPTH.
// stall is combinational from ID; fwd_sel_a/b are registered for EX one cycle later.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  fwd_hazard_unit_if.slave hz
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ent_t;

  ent_t             sh [1:DEPTH];
  logic [SEL_W-1:0] sel_nxt [2];
  logic             lu [2];
  logic             stall;
  logic             accept;
  logic [SEL_W-1:0] sel_a_q;
  logic [SEL_W-1:0] sel_b_q;
  logic [CNT_W-1:0] cnt_q;

  // Scan oldest to youngest so the youngest matching writer is the last to assign.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      sel_nxt[o] = '0;
      lu[o]      = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (((o == 0) ? hz.id_rs1_used : hz.id_rs2_used) && hz.id_valid &&
            (((o == 0) ? hz.id_rs1 : hz.id_rs2) != '0) &&
            sh[k].v && sh[k].wr &&
            (sh[k].rd == ((o == 0) ? hz.id_rs1 : hz.id_rs2))) begin
          sel_nxt[o] = (k < DEPTH) ? SEL_W'(k + 1) : '0;
          lu[o]      = sh[k].ld && (k + 1 <= LOAD_STAGE);
        end
      end
    end
  end

  assign stall  = (lu[0] | lu[1]) & ~hz.flush;
  assign accept = hz.id_valid & ~stall & ~hz.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sh[k] <= '0;
      end
      sel_a_q <= '0;
      sel_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      sh[1] <= accept ? '{v: 1'b1, rd: hz.id_rd, wr: hz.id_regwrite, ld: hz.id_is_load} : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        sh[k] <= sh[k-1];
      end
      sel_a_q <= accept ? sel_nxt[0] : '0;
      sel_b_q <= accept ? sel_nxt[1] : '0;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign hz.stall        = stall;
  assign hz.fwd_sel_a    = sel_a_q;
  assign hz.fwd_sel_b    = sel_b_q;
  assign hz.stall_cycles = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Drives two units (LOAD_STAGE 2 with 16-bit counter, LOAD_STAGE 3 with 3-bit counter)
// with identical ID streams and checks both against an instruction-history model.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) hz2 ();
  fwd_hazard_unit_if #(.REG_AW(5), .DEPTH(3), .CNT_W(3))  hz3 ();

  fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .hz(hz2.slave));
  fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hz(hz3.slave));

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } rec_t;

  int   total = 0;
  int   bad   = 0;
  // hist[d][k]: instruction that entered EX k cycles ago (k=1 youngest)
  rec_t hist [2][1:3];
  int   ls   [2] = '{2, 3};
  int   cmax [2] = '{65535, 7};
  int   m_sa [2];
  int   m_sb [2];
  int   m_cnt[2];
  int   o_stall[2];
  int   o_sa [2];
  int   o_sb [2];
  int   o_cnt[2];

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_stall(int d);
    return (d == 0) ? int'(hz2.stall) : int'(hz3.stall);
  endfunction
  function automatic int dut_sa(int d);
    return (d == 0) ? int'(hz2.fwd_sel_a) : int'(hz3.fwd_sel_a);
  endfunction
  function automatic int dut_sb(int d);
    return (d == 0) ? int'(hz2.fwd_sel_b) : int'(hz3.fwd_sel_b);
  endfunction
  function automatic int dut_cnt(int d);
    return (d == 0) ? int'(hz2.stall_cycles) : int'(hz3.stall_cycles);
  endfunction

  // Where EX must take source s from, given the instructions already in flight.
  function automatic int pick(int d, int s, bit used, bit valid, output bit lu);
    int  sel;
    bit  found;
    sel   = 0;
    found = 1'b0;
    lu    = 1'b0;
    if (valid && used && s != 0) begin
      for (int k = 1; k <= 3; k++) begin
        if (!found && hist[d][k].v && hist[d][k].wr && hist[d][k].rd == s) begin
          found = 1'b1;
          lu    = hist[d][k].ld && (k + 1 <= ls[d]);
          sel   = (k < 3) ? k + 1 : 0;
        end
      end
    end
    return sel;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 1; k <= 3; k++) hist[d][k] = '{1'b0, 0, 1'b0, 1'b0};
      m_sa[d] = 0;
      m_sb[d] = 0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld, bit fl);
    hz2.id_valid = v;      hz3.id_valid = v;
    hz2.id_rs1 = 5'(rs1);  hz3.id_rs1 = 5'(rs1);
    hz2.id_rs2 = 5'(rs2);  hz3.id_rs2 = 5'(rs2);
    hz2.id_rs1_used = u1;  hz3.id_rs1_used = u1;
    hz2.id_rs2_used = u2;  hz3.id_rs2_used = u2;
    hz2.id_rd = 5'(rd);    hz3.id_rd = 5'(rd);
    hz2.id_regwrite = wr;  hz3.id_regwrite = wr;
    hz2.id_is_load = ld;   hz3.id_is_load = ld;
    hz2.flush = fl;        hz3.flush = fl;
  endtask

  task automatic step(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld, bit fl);
    int esa[2];
    int esb[2];
    bit es[2];
    bit la, lb, acc;
    @(negedge clk);
    drive(v, rs1, rs2, u1, u2, rd, wr, ld, fl);
    #1;
    for (int d = 0; d < 2; d++) begin
      esa[d] = pick(d, rs1, u1, v, la);
      esb[d] = pick(d, rs2, u2, v, lb);
      es[d]  = (la | lb) & !fl;
      o_stall[d] = dut_stall(d);
      check($sformatf("stall_ls%0d", ls[d]), o_stall[d], int'(es[d]));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      acc = v & !es[d] & !fl;
      for (int k = 3; k >= 2; k--) hist[d][k] = hist[d][k-1];
      hist[d][1] = acc ? '{1'b1, rd, wr, ld} : '{1'b0, 0, 1'b0, 1'b0};
      m_sa[d] = acc ? esa[d] : 0;
      m_sb[d] = acc ? esb[d] : 0;
      if (es[d] && m_cnt[d] < cmax[d]) m_cnt[d]++;
      o_sa[d]  = dut_sa(d);
      o_sb[d]  = dut_sb(d);
      o_cnt[d] = dut_cnt(d);
      check($sformatf("sel_a_ls%0d", ls[d]), o_sa[d], m_sa[d]);
      check($sformatf("sel_b_ls%0d", ls[d]), o_sb[d], m_sb[d]);
      check($sformatf("cnt_ls%0d", ls[d]), o_cnt[d], m_cnt[d]);
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(int rd, int rs1, int rs2);
    step(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
  endtask
  task automatic load(int rd, int rs1);
    step(1, rs1, 0, 1, 0, rd, 1, 1, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  initial begin
    int c0, c1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_stall_ls%0d", ls[d]), dut_stall(d), 0);
      check($sformatf("rst_sel_a_ls%0d", ls[d]), dut_sa(d), 0);
      check($sformatf("rst_sel_b_ls%0d", ls[d]), dut_sb(d), 0);
      check($sformatf("rst_cnt_ls%0d", ls[d]), dut_cnt(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ALU dependency
    alu(5, 1, 2);
    alu(6, 5, 1);
    check("t1_stall", o_stall[0], 0);
    check("t1_sel_a", o_sa[0], 2);
    check("t1_sel_b", o_sb[0], 0);
    drain();

    // distance 2 forwards from WB, distance 3 reads the write-first regfile
    alu(5, 1, 2); nop(); alu(7, 1, 5);
    check("t2_sel_b_wb", o_sb[0], 3);
    drain();
    alu(5, 1, 2); nop(); nop(); alu(7, 1, 5);
    check("t2_sel_b_rf", o_sb[0], 0);
    drain();

    // load-use: one bubble at LOAD_STAGE=2, two at LOAD_STAGE=3
    c0 = o_cnt[0];
    c1 = o_cnt[1];
    load(7, 1);
    alu(8, 7, 7);
    check("t3_stall1_ls2", o_stall[0], 1);
    check("t3_stall1_ls3", o_stall[1], 1);
    alu(8, 7, 7);
    check("t3_stall2_ls2", o_stall[0], 0);
    check("t3_sel_a_ls2", o_sa[0], 3);
    check("t3_sel_b_ls2", o_sb[0], 3);
    check("t3_cnt_ls2", o_cnt[0] - c0, 1);
    check("t3_stall2_ls3", o_stall[1], 1);
    alu(8, 7, 7);
    check("t3_stall3_ls3", o_stall[1], 0);
    check("t3_sel_a_ls3", o_sa[1], 0);
    check("t3_cnt_ls3", o_cnt[1] - c1, 2);
    drain();

    // x0 never forwards; unused source never forwards
    alu(0, 1, 2); alu(3, 0, 0);
    check("t4_x0_sel_a", o_sa[0], 0);
    check("t4_x0_stall", o_stall[0], 0);
    drain();
    alu(5, 1, 2);
    step(1, 5, 1, 0, 1, 9, 1, 0, 0);
    check("t4_unused_sel_a", o_sa[0], 0);
    drain();

    // youngest writer wins
    alu(5, 1, 2); alu(5, 3, 4); alu(9, 5, 5);
    check("t5_sel_a", o_sa[0], 2);
    check("t5_sel_b", o_sb[0], 2);
    drain();

    // flush overrides a load-use stall
    c0 = o_cnt[0];
    load(7, 1);
    step(1, 7, 1, 1, 1, 8, 1, 0, 1);
    check("t6_stall", o_stall[0], 0);
    check("t6_sel_a", o_sa[0], 0);
    check("t6_cnt", o_cnt[0] - c0, 0);
    drain();

    // asynchronous reset in the middle of a stall
    load(7, 1);
    @(negedge clk);
    drive(1, 7, 7, 1, 1, 8, 1, 0, 0);
    #1;
    check("t7_pre_stall", dut_stall(0), 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t7_stall_ls%0d", ls[d]), dut_stall(d), 0);
      check($sformatf("t7_sel_a_ls%0d", ls[d]), dut_sa(d), 0);
      check($sformatf("t7_sel_b_ls%0d", ls[d]), dut_sb(d), 0);
      check($sformatf("t7_cnt_ls%0d", ls[d]), dut_cnt(d), 0);
    end
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    check("sat_cnt_ls3", o_cnt[1], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
